// File: rtl/note_event_encoder.sv
// -----------------------------------------------------------------------------
// note_event_encoder
//
// Purpose:
//   Producer side of the note-event interface feeding the staff renderer.
//   It takes one pitch sample per eighth-note tick and merges equal
//   consecutive samples into runs. Each run is split into power-of-two
//   pieces (eighth, quarter, half, whole) that never cross a measure
//   boundary, and one note or rest event is emitted per piece.
//
// Ports:
//   pixel_clk_in       system (pixel) clock
//   rst_in             asynchronous, active-high reset
//   tick_in            one-cycle pulse per eighth-note period
//   pitch_valid_in     1 = pitch sounding at this tick, 0 = rest
//   pitch_in[5:0]      note code, sampled on tick_in
//   flush_in           pulse: close and emit the open run now
//   note_out[5:0]      pitch of the emitted event, 0 for rests
//   note_type_out[7:0] one-hot; bit0..3 note of 1/2/4/8 eighths,
//                      bit4..7 rest of 1/2/4/8 eighths
//   new_note_out       one-cycle strobe qualifying note_out/note_type_out
//   measure_pos_out    eighth position of the next event in its measure
//   measure_count_out  number of completed measures
//   busy_out           high while emitting (FLUSH or GAP)
//   full_out           TOTAL_MEASURES measures completed
//   overrun_out        sticky; a tick was dropped
// -----------------------------------------------------------------------------
module note_event_encoder #(
    parameter int TOTAL_MEASURES      = 20,
    // Fixed 4/4 time counted in eighths; only 8 is supported.
    parameter int EIGHTHS_PER_MEASURE = 8
) (
    input  logic       pixel_clk_in,
    input  logic       rst_in,
    input  logic       tick_in,
    input  logic       pitch_valid_in,
    input  logic [5:0] pitch_in,
    input  logic       flush_in,
    output logic [5:0] note_out,
    output logic [7:0] note_type_out,
    output logic       new_note_out,
    output logic [2:0] measure_pos_out,
    output logic [4:0] measure_count_out,
    output logic       busy_out,
    output logic       full_out,
    output logic       overrun_out
);

    typedef enum logic [1:0] {
        ST_ACCUM,   // collecting ticks into the open run
        ST_FLUSH,   // strobe cycle for one piece
        ST_GAP      // spacer cycle; advances position and remaining length
    } state_t;

    // Largest power-of-two piece that fits, as log2. len never exceeds 8.
    function automatic logic [1:0] piece_log(input logic [3:0] len);
        if (len[3])      return 2'd3;
        else if (len[2]) return 2'd2;
        else if (len[1]) return 2'd1;
        else             return 2'd0;
    endfunction

    state_t      r_state;
    logic [2:0]  r_pos;
    logic [4:0]  r_meas_cnt;
    logic        r_full;
    logic        r_overrun;

    // Open run
    logic        r_open;
    logic        r_sym_rest;
    logic [5:0]  r_sym_pitch;
    logic [2:0]  r_start;
    logic [3:0]  r_len;

    // Run currently being emitted
    logic        r_emit_rest;
    logic [5:0]  r_emit_pitch;
    logic [3:0]  r_rem;
    logic [1:0]  r_piece_log;

    // Run that opens once the current emission finishes
    logic        r_pend_valid;
    logic        r_pend_rest;
    logic [5:0]  r_pend_pitch;
    logic [2:0]  r_pend_start;

    // Single tick captured while busy
    logic        r_tick_pend;
    logic        r_tick_rest;
    logic [5:0]  r_tick_pitch;

    // Registered event outputs
    logic [5:0]  r_note;
    logic [7:0]  r_note_type;
    logic        r_new_note;

    logic        w_in_rest;
    logic [5:0]  w_in_pitch;
    logic        w_tick_act;
    logic        w_tick_rest;
    logic [5:0]  w_tick_pitch;
    logic        w_tick_match;
    logic        w_boundary;
    logic [3:0]  w_piece_len;
    logic [3:0]  w_gap_rem;
    logic [3:0]  w_pos_sum;
    logic [4:0]  w_meas_inc;
    logic        w_full_now;
    logic        w_emit_rest;
    logic [5:0]  w_emit_pitch;
    logic [3:0]  w_emit_len;
    logic [1:0]  w_emit_log;
    logic        w_do_emit;

    assign w_in_rest    = ~pitch_valid_in;
    assign w_in_pitch   = pitch_valid_in ? pitch_in : 6'd0;

    // A tick captured while busy is served before any live tick.
    assign w_tick_act   = r_tick_pend | tick_in;
    assign w_tick_rest  = r_tick_pend ? r_tick_rest  : w_in_rest;
    assign w_tick_pitch = r_tick_pend ? r_tick_pitch : w_in_pitch;
    assign w_tick_match = (w_tick_rest == r_sym_rest) && (w_tick_pitch == r_sym_pitch);

    assign w_boundary   = r_open &&
                          (({1'b0, r_start} + r_len) == 4'(EIGHTHS_PER_MEASURE));

    assign w_piece_len  = 4'd1 << r_piece_log;
    assign w_gap_rem    = r_rem - w_piece_len;
    assign w_pos_sum    = {1'b0, r_pos} + w_piece_len;   // bit 3 = measure wrap
    assign w_meas_inc   = r_meas_cnt + 5'd1;
    assign w_full_now   = w_pos_sum[3] && (w_meas_inc == 5'(TOTAL_MEASURES));

    // The next piece comes from the open run when leaving ACCUM and from the
    // remainder of the emitting run when leaving GAP.
    assign w_emit_rest  = (r_state == ST_GAP) ? r_emit_rest  : r_sym_rest;
    assign w_emit_pitch = (r_state == ST_GAP) ? r_emit_pitch : r_sym_pitch;
    assign w_emit_len   = (r_state == ST_GAP) ? w_gap_rem    : r_len;
    assign w_emit_log   = piece_log(w_emit_len);

    always_comb begin
        w_do_emit = 1'b0;
        case (r_state)
            ST_ACCUM: begin
                if (!r_full) begin
                    if (w_boundary)
                        w_do_emit = 1'b1;
                    else if (w_tick_act)
                        w_do_emit = r_open && !w_tick_match;
                    else
                        w_do_emit = flush_in && r_open;
                end
            end
            ST_GAP:  w_do_emit = (w_gap_rem != 4'd0) && !w_full_now;
            default: w_do_emit = 1'b0;
        endcase
    end

    // NOTE: every state register is assigned with <= so that all updates in a
    // cycle see the same pre-edge values; later assignments in this block
    // intentionally override earlier defaults.
    always_ff @(posedge pixel_clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state      <= ST_ACCUM;
            r_pos        <= 3'd0;
            r_meas_cnt   <= 5'd0;
            r_full       <= 1'b0;
            r_overrun    <= 1'b0;
            r_open       <= 1'b0;
            r_sym_rest   <= 1'b0;
            r_sym_pitch  <= 6'd0;
            r_start      <= 3'd0;
            r_len        <= 4'd0;
            r_emit_rest  <= 1'b0;
            r_emit_pitch <= 6'd0;
            r_rem        <= 4'd0;
            r_piece_log  <= 2'd0;
            r_pend_valid <= 1'b0;
            r_pend_rest  <= 1'b0;
            r_pend_pitch <= 6'd0;
            r_pend_start <= 3'd0;
            r_tick_pend  <= 1'b0;
            r_tick_rest  <= 1'b0;
            r_tick_pitch <= 6'd0;
            r_note       <= 6'd0;
            r_note_type  <= 8'd0;
            r_new_note   <= 1'b0;
        end else begin
            r_new_note <= 1'b0;

            case (r_state)
                ST_ACCUM: begin
                    if (r_full) begin
                        // Storage is exhausted: drop everything.
                        r_open      <= 1'b0;
                        r_tick_pend <= 1'b0;
                    end else if (w_boundary) begin
                        r_pend_valid <= 1'b0;
                    end else if (w_tick_act) begin
                        // Serving a captured tick while a new one arrives:
                        // the new one takes the capture slot.
                        if (r_tick_pend && tick_in) begin
                            r_tick_rest  <= w_in_rest;
                            r_tick_pitch <= w_in_pitch;
                        end else begin
                            r_tick_pend <= 1'b0;
                        end

                        if (!r_open) begin
                            r_open      <= 1'b1;
                            r_sym_rest  <= w_tick_rest;
                            r_sym_pitch <= w_tick_pitch;
                            r_start     <= r_pos;
                            r_len       <= 4'd1;
                        end else if (w_tick_match) begin
                            r_len <= r_len + 4'd1;
                        end else begin
                            r_pend_valid <= 1'b1;
                            r_pend_rest  <= w_tick_rest;
                            r_pend_pitch <= w_tick_pitch;
                            r_pend_start <= r_start + r_len[2:0];
                        end
                    end else if (flush_in && r_open) begin
                        r_pend_valid <= 1'b0;
                    end
                end

                ST_FLUSH: begin
                    r_state <= ST_GAP;
                end

                ST_GAP: begin
                    r_rem <= w_gap_rem;
                    r_pos <= w_pos_sum[2:0];
                    if (w_pos_sum[3]) begin
                        r_meas_cnt <= w_meas_inc;
                        if (w_full_now)
                            r_full <= 1'b1;
                    end
                    if (!w_do_emit) begin
                        r_state      <= ST_ACCUM;
                        r_pend_valid <= 1'b0;
                        if (r_pend_valid && !w_full_now) begin
                            r_open      <= 1'b1;
                            r_sym_rest  <= r_pend_rest;
                            r_sym_pitch <= r_pend_pitch;
                            r_start     <= r_pend_start;
                            r_len       <= 4'd1;
                        end
                    end
                end

                default: r_state <= ST_ACCUM;
            endcase

            // Start one piece: the strobe is high for the whole FLUSH cycle.
            if (w_do_emit) begin
                r_state      <= ST_FLUSH;
                r_open       <= 1'b0;
                r_emit_rest  <= w_emit_rest;
                r_emit_pitch <= w_emit_pitch;
                r_rem        <= w_emit_len;
                r_piece_log  <= w_emit_log;
                r_new_note   <= 1'b1;
                r_note       <= w_emit_rest ? 6'd0 : w_emit_pitch;
                r_note_type  <= 8'd1 << {w_emit_rest, w_emit_log};
            end

            // Ticks that cannot be served this cycle: keep the first, flag
            // any further ones as lost.
            if (!r_full && tick_in && (r_state != ST_ACCUM || w_boundary)) begin
                if (r_tick_pend) begin
                    r_overrun <= 1'b1;
                end else begin
                    r_tick_pend  <= 1'b1;
                    r_tick_rest  <= w_in_rest;
                    r_tick_pitch <= w_in_pitch;
                end
            end
        end
    end

    assign note_out          = r_note;
    assign note_type_out     = r_note_type;
    assign new_note_out      = r_new_note;
    assign measure_pos_out   = r_pos;
    assign measure_count_out = r_meas_cnt;
    assign busy_out          = (r_state != ST_ACCUM);
    assign full_out          = r_full;
    assign overrun_out       = r_overrun;

endmodule

// File: tb/tb_note_event_encoder.sv
// -----------------------------------------------------------------------------
// tb_note_event_encoder
//
// Directed bench for note_event_encoder. Inputs are driven and outputs are
// checked 1 ns after the falling clock edge; a monitor records every strobe
// (pitch, type, cycle index) on the falling edge.
// -----------------------------------------------------------------------------
module tb_note_event_encoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       pv = 1'b0;
    logic [5:0] pitch = 6'd0;
    logic       fl = 1'b0;

    logic [5:0] note_out;
    logic [7:0] note_type_out;
    logic       new_note_out;
    logic [2:0] measure_pos_out;
    logic [4:0] measure_count_out;
    logic       busy_out;
    logic       full_out;
    logic       overrun_out;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int last_tick_cyc = 0;

    typedef struct {
        logic [5:0] note;
        logic [7:0] ntype;
        int         c;
    } strobe_t;

    strobe_t sq[$];

    note_event_encoder #(
        .TOTAL_MEASURES      (20),
        .EIGHTHS_PER_MEASURE (8)
    ) dut (
        .pixel_clk_in      (clk),
        .rst_in            (rst),
        .tick_in           (tick),
        .pitch_valid_in    (pv),
        .pitch_in          (pitch),
        .flush_in          (fl),
        .note_out          (note_out),
        .note_type_out     (note_type_out),
        .new_note_out      (new_note_out),
        .measure_pos_out   (measure_pos_out),
        .measure_count_out (measure_count_out),
        .busy_out          (busy_out),
        .full_out          (full_out),
        .overrun_out       (overrun_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (new_note_out)
            sq.push_back('{note_out, note_type_out, cyc});
    end

    // Out-of-range entries read as all-X so a missing strobe fails its check.
    function automatic strobe_t get_s(input int i);
        strobe_t s;
        s = '{6'bx, 8'bx, -1};
        if (i < sq.size())
            s = sq[i];
        return s;
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick = 1'b0;
        fl = 1'b0;
        step(2);
        rst = 1'b0;
        step(1);
        sq.delete();
    endtask

    task automatic do_tick(input logic v, input logic [5:0] p, input int idle);
        tick = 1'b1;
        pv = v;
        pitch = p;
        step(1);
        tick = 1'b0;
        last_tick_cyc = cyc;
        step(idle);
    endtask

    task automatic do_flush(input int idle);
        fl = 1'b1;
        step(1);
        fl = 1'b0;
        step(idle);
    endtask

    task automatic test_reset();
        strobe_t s;
        rst = 1'b1;
        tick = 1'b1;
        pv = 1'b1;
        pitch = 6'b100000;
        fl = 1'b1;
        step(3);
        n_checks++;
        if ({note_out, note_type_out, new_note_out, measure_pos_out, measure_count_out,
             busy_out, full_out, overrun_out} !== 26'd0) begin
            n_errors++;
            $display("FAIL reset_outputs: got note=%h type=%h new=%b pos=%0d cnt=%0d busy=%b full=%b ovr=%b, expected all 0",
                     note_out, note_type_out, new_note_out, measure_pos_out, measure_count_out,
                     busy_out, full_out, overrun_out);
        end
        tick = 1'b0;
        fl = 1'b0;
        rst = 1'b0;
        step(4);
        n_checks++;
        if (sq.size() != 0) begin
            n_errors++;
            s = get_s(0);
            $display("FAIL reset_no_strobe: got %0d strobes (first type %h), expected 0", sq.size(), s.ntype);
        end
    endtask

    // Run of 3 then a new pitch: quarter then eighth, two cycles apart.
    task automatic test_split3();
        strobe_t s0, s1;
        int t;
        do_reset();
        repeat (3) do_tick(1'b1, 6'b100100, 1);
        do_tick(1'b1, 6'b100111, 0);
        t = last_tick_cyc;
        step(6);
        s0 = get_s(0);
        s1 = get_s(1);
        n_checks++;
        if (sq.size() != 2) begin
            n_errors++;
            $display("FAIL split3_count: got %0d strobes, expected 2", sq.size());
        end
        n_checks++;
        if (s0.note !== 6'b100100 || s0.ntype !== 8'h02 || s0.c != t) begin
            n_errors++;
            $display("FAIL split3_first: got note=%b type=%h cyc=%0d, expected note=100100 type=02 cyc=%0d",
                     s0.note, s0.ntype, s0.c, t);
        end
        n_checks++;
        if (s1.note !== 6'b100100 || s1.ntype !== 8'h01 || s1.c != t + 2) begin
            n_errors++;
            $display("FAIL split3_second: got note=%b type=%h cyc=%0d, expected note=100100 type=01 cyc=%0d",
                     s1.note, s1.ntype, s1.c, t + 2);
        end
        n_checks++;
        if (measure_pos_out !== 3'd3 || busy_out !== 1'b0) begin
            n_errors++;
            $display("FAIL split3_pos: got pos=%0d busy=%b, expected pos=3 busy=0", measure_pos_out, busy_out);
        end
    endtask

    // Eight equal ticks fill the measure: one whole note from the boundary.
    task automatic test_whole();
        strobe_t s0;
        int t;
        do_reset();
        repeat (8) do_tick(1'b1, 6'b101001, 1);
        t = last_tick_cyc;
        step(6);
        s0 = get_s(0);
        n_checks++;
        if (sq.size() != 1 || s0.note !== 6'b101001 || s0.ntype !== 8'h08 || s0.c != t + 1) begin
            n_errors++;
            $display("FAIL whole_strobe: got n=%0d note=%b type=%h cyc=%0d, expected n=1 note=101001 type=08 cyc=%0d",
                     sq.size(), s0.note, s0.ntype, s0.c, t + 1);
        end
        n_checks++;
        if (measure_count_out !== 5'd1 || measure_pos_out !== 3'd0) begin
            n_errors++;
            $display("FAIL whole_measure: got cnt=%0d pos=%0d, expected cnt=1 pos=0",
                     measure_count_out, measure_pos_out);
        end
    endtask

    // Two rest ticks then a pitch: one quarter rest.
    task automatic test_rest();
        strobe_t s0;
        int t;
        do_reset();
        repeat (2) do_tick(1'b0, 6'b010101, 1);
        do_tick(1'b1, 6'b100000, 0);
        t = last_tick_cyc;
        step(6);
        s0 = get_s(0);
        n_checks++;
        if (sq.size() != 1 || s0.note !== 6'd0 || s0.ntype !== 8'h20 || s0.c != t) begin
            n_errors++;
            $display("FAIL rest_strobe: got n=%0d note=%b type=%h cyc=%0d, expected n=1 note=000000 type=20 cyc=%0d",
                     sq.size(), s0.note, s0.ntype, s0.c, t);
        end
        n_checks++;
        if (measure_pos_out !== 3'd2) begin
            n_errors++;
            $display("FAIL rest_pos: got %0d, expected 2", measure_pos_out);
        end
    endtask

    // Run starting at pos 6 is cut by the barline after 2 eighths.
    task automatic test_boundary();
        strobe_t s0, s1, s2, s3;
        do_reset();
        repeat (6) do_tick(1'b1, 6'b100010, 1);
        do_tick(1'b1, 6'b101100, 6);
        do_tick(1'b1, 6'b101100, 4);
        do_tick(1'b1, 6'b101100, 4);
        s0 = get_s(0);
        s1 = get_s(1);
        s2 = get_s(2);
        n_checks++;
        if (sq.size() != 3 || s0.note !== 6'b100010 || s0.ntype !== 8'h04 ||
            s1.note !== 6'b100010 || s1.ntype !== 8'h02) begin
            n_errors++;
            $display("FAIL boundary_six: got n=%0d %b/%h %b/%h, expected n=3 100010/04 100010/02",
                     sq.size(), s0.note, s0.ntype, s1.note, s1.ntype);
        end
        n_checks++;
        if (s2.note !== 6'b101100 || s2.ntype !== 8'h02) begin
            n_errors++;
            $display("FAIL boundary_cut: got note=%b type=%h, expected note=101100 type=02", s2.note, s2.ntype);
        end
        n_checks++;
        if (measure_count_out !== 5'd1 || measure_pos_out !== 3'd0) begin
            n_errors++;
            $display("FAIL boundary_measure: got cnt=%0d pos=%0d, expected cnt=1 pos=0",
                     measure_count_out, measure_pos_out);
        end
        // The third eighth is an open run at pos 0; flush_in emits it.
        do_flush(4);
        s3 = get_s(3);
        n_checks++;
        if (sq.size() != 4 || s3.note !== 6'b101100 || s3.ntype !== 8'h01 || measure_pos_out !== 3'd1) begin
            n_errors++;
            $display("FAIL boundary_newrun: got n=%0d note=%b type=%h pos=%0d, expected n=4 note=101100 type=01 pos=1",
                     sq.size(), s3.note, s3.ntype, measure_pos_out);
        end
    endtask

    // Ticks in FLUSH and GAP: first is kept, second is dropped and sticky.
    task automatic test_back_to_back();
        strobe_t s0, s1;
        int t;
        do_reset();
        repeat (2) do_tick(1'b1, 6'b100001, 1);
        tick = 1'b1;
        pv = 1'b1;
        pitch = 6'b100011;
        step(1);                // mismatch captured: FLUSH follows
        t = cyc;
        step(1);                // same pitch during FLUSH: kept
        pitch = 6'b110000;
        step(1);                // tick during GAP: dropped
        tick = 1'b0;
        step(3);
        s0 = get_s(0);
        n_checks++;
        if (sq.size() != 1 || s0.note !== 6'b100001 || s0.ntype !== 8'h02 || s0.c != t) begin
            n_errors++;
            $display("FAIL b2b_first: got n=%0d note=%b type=%h cyc=%0d, expected n=1 note=100001 type=02 cyc=%0d",
                     sq.size(), s0.note, s0.ntype, s0.c, t);
        end
        n_checks++;
        if (overrun_out !== 1'b1) begin
            n_errors++;
            $display("FAIL b2b_overrun: got %b, expected 1", overrun_out);
        end
        do_flush(4);
        s1 = get_s(1);
        n_checks++;
        if (sq.size() != 2 || s1.note !== 6'b100011 || s1.ntype !== 8'h02 || measure_pos_out !== 3'd4) begin
            n_errors++;
            $display("FAIL b2b_kept: got n=%0d note=%b type=%h pos=%0d, expected n=2 note=100011 type=02 pos=4",
                     sq.size(), s1.note, s1.ntype, measure_pos_out);
        end
        do_tick(1'b1, 6'b100011, 4);
        do_flush(4);
        n_checks++;
        if (overrun_out !== 1'b1) begin
            n_errors++;
            $display("FAIL b2b_sticky: got %b, expected 1", overrun_out);
        end
        do_reset();
        n_checks++;
        if (overrun_out !== 1'b0) begin
            n_errors++;
            $display("FAIL b2b_reset_clear: got %b, expected 0", overrun_out);
        end
    endtask

    // Twenty whole measures fill the renderer; further input is ignored.
    task automatic test_full();
        int n_whole;
        do_reset();
        for (int m = 0; m < 20; m++)
            for (int k = 0; k < 8; k++)
                do_tick(1'b1, 6'b100101, 3);
        step(4);
        n_whole = 0;
        foreach (sq[i])
            if (sq[i].note === 6'b100101 && sq[i].ntype === 8'h08)
                n_whole++;
        n_checks++;
        if (sq.size() != 20 || n_whole != 20) begin
            n_errors++;
            $display("FAIL full_strobes: got n=%0d whole=%0d, expected n=20 whole=20", sq.size(), n_whole);
        end
        n_checks++;
        if (full_out !== 1'b1 || measure_count_out !== 5'd20 || overrun_out !== 1'b0) begin
            n_errors++;
            $display("FAIL full_flag: got full=%b cnt=%0d ovr=%b, expected full=1 cnt=20 ovr=0",
                     full_out, measure_count_out, overrun_out);
        end
        do_tick(1'b1, 6'b100101, 4);
        do_tick(1'b1, 6'b111000, 4);
        do_flush(6);
        n_checks++;
        if (sq.size() != 20 || full_out !== 1'b1 || measure_count_out !== 5'd20) begin
            n_errors++;
            $display("FAIL full_ignore: got n=%0d full=%b cnt=%0d, expected n=20 full=1 cnt=20",
                     sq.size(), full_out, measure_count_out);
        end
    endtask

    // Asynchronous reset during a strobe cycle clears outputs at once.
    task automatic test_reset_mid_strobe();
        do_reset();
        do_tick(1'b1, 6'b100110, 1);
        do_tick(1'b1, 6'b101110, 0);
        n_checks++;
        if (new_note_out !== 1'b1 || busy_out !== 1'b1) begin
            n_errors++;
            $display("FAIL midrst_pre: got new=%b busy=%b, expected new=1 busy=1", new_note_out, busy_out);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({note_out, note_type_out, new_note_out, measure_pos_out, measure_count_out,
             busy_out, full_out, overrun_out} !== 26'd0) begin
            n_errors++;
            $display("FAIL midrst_clear: got note=%h type=%h new=%b pos=%0d cnt=%0d busy=%b full=%b ovr=%b, expected all 0",
                     note_out, note_type_out, new_note_out, measure_pos_out, measure_count_out,
                     busy_out, full_out, overrun_out);
        end
        step(2);
        sq.delete();
        rst = 1'b0;
        step(8);
        n_checks++;
        if (sq.size() != 0 || busy_out !== 1'b0) begin
            n_errors++;
            $display("FAIL midrst_no_partial: got n=%0d busy=%b, expected n=0 busy=0", sq.size(), busy_out);
        end
    endtask

    initial begin
        test_reset();
        test_split3();
        test_whole();
        test_rest();
        test_boundary();
        test_back_to_back();
        test_full();
        test_reset_mid_strobe();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Absolute time limit so the run always ends by itself.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
